sk9822_frame_feeder: RTL
========================

# sk9822_frame_feeder

Upstream stage of the SK9822 serial driver. Holds per-LED colour and brightness in a double-buffered register file written by the pattern/control logic. Emits each refresh as a word stream over a valid/ready handshake: start frame, one 32-bit LED frame per LED, end frame. The downstream serializer shifts each accepted word out MSB-first on the SK9822 clock/data pins.

## Interface
- `LED_NUM`, default 12: LEDs in the chain; legal range 1..64.
- `AW`, default `$clog2(LED_NUM)` (min 1): LED address width.
- `START_WORD`, default 32'h0000_0000: start frame.
- `END_WORD`, default 32'hFFFF_FFFF: end frame.

Ports:
- `clk` in 1: system clock (27 MHz on board).
- `rst_n` in 1: reset, asynchronous, active-low.
- `run` in 1: level; while high, frames repeat back-to-back.
- `wr_en` in 1: write strobe into shadow bank.
- `wr_addr` in AW: LED index, 0 = first LED after controller.
- `wr_data` in 29: {brightness[4:0], B[7:0], G[7:0], R[7:0]} in SK9822 wire order.
- `commit` in 1: one-cycle pulse; request shadow→active swap.
- `word_data` out 32: current stream word.
- `word_valid` out 1: word_data valid.
- `word_ready` in 1: downstream accepts word this cycle.
- `word_last` out 1: high with END word.
- `swap_pending` out 1: commit seen, swap not yet done.
- `frame_done` out 1: one-cycle pulse when END word accepted.

## Operation
- Storage: two banks, each LED_NUM × 29 bits; `bank_sel` selects active. Writes always go to bank `!bank_sel`.
- Write: `wr_en` with `wr_addr < LED_NUM` updates shadow entry next edge; `wr_addr >= LED_NUM` is ignored, no side effect.
- Commit: `commit` sets `swap_pending`. Swap (toggle `bank_sel`, clear pending) happens only at a frame boundary: in IDLE, or on the cycle the END word is accepted. Swap is never mid-frame.
- `commit` in the same cycle as a swap is absorbed by that swap; pending stays 0.
- `wr_en` in the same cycle as a swap writes the old shadow bank, which becomes active. That data appears in the next frame.
- After a swap, the new shadow bank holds the previously active contents. No copy-back. The writer rewrites what it changes.
- FSM states:
  - IDLE: valid=0. If `run` is high, go to START.
  - START: word=START_WORD. On accept, go to PIXEL with idx=0.
  - PIXEL: word={3'b111, active[idx]}. On accept, if idx==LED_NUM-1 go to END, else idx+1.
  - END: word=END_WORD, last=1. On accept, pulse frame_done, do pending swap, then go to START if `run` is high, else IDLE.
- `run` falling mid-frame does not abort. The frame completes through END.
- The PIXEL word is read from the active bank when the state/idx is entered. It is registered and held stable while stalled. Writes and swaps cannot alter a word already presented.

## Timing
- All outputs registered. Reset values: word_data=0, word_valid=0, word_last=0, swap_pending=0, frame_done=0, bank_sel=0, idx=0, state IDLE, both banks all-zero.
- Handshake: a transfer occurs on an edge with valid&&ready high. While valid is high and ready is low, word_data, word_last and word_valid hold.
- Latency: `run` sampled high in IDLE at edge N gives valid=1 with START_WORD after edge N.
- Throughput: with ready tied high, one word per clk. A frame is LED_NUM+2 cycles, with no gap between END and the next START while `run` stays high.
- `frame_done` is high the cycle after the END transfer edge. The swap is visible to the PIXEL read of the next frame.
- `rst_n` low at any time, including mid-frame or mid-stall: immediate return to reset values. Downstream must treat a dropped valid as an aborted frame.

## Test plan
- Basic frame: reset, write LED0=29'h0F_0000FF, commit, run=1, ready=1 → words 0x00000000, 0xEF0000FF, then 11× 0xE0000000, then 0xFFFFFFFF with last=1; frame_done pulses once.
- Backpressure: random ready at 30% duty → word sequence identical to the basic frame; data and last never change while valid && !ready.
- Mid-frame commit: commit during PIXEL idx=5 with new LED0 data → the current frame keeps the old values; swap_pending=1 until the END transfer; the next frame carries the new data.
- Boundary: commit and wr_en(addr 3) in the same cycle as the END transfer → pending stays 0; addr-3 data appears in the next frame. wr_addr=12 → no entry changes.
- Run drop: run=0 at PIXEL idx=2 → the frame completes through END, then IDLE with valid=0.
- Async reset: assert rst_n low mid-stall in PIXEL → all outputs 0 immediately; after release with run=1, the stream restarts at START_WORD with all LEDs 0xE0000000.

Source files
------------

// File: rtl/sk9822_frame_feeder.sv
// sk9822_frame_feeder
// Double-buffered per-LED colour store feeding a 32-bit word stream
// (start frame, one LED frame per LED, end frame) over valid/ready.
// The active bank only changes at frame boundaries, so a frame is always
// rendered from one consistent snapshot of the LED colours.
module sk9822_frame_feeder #(
    parameter int          LED_NUM    = 12,
    parameter int          AW         = (LED_NUM > 1) ? $clog2(LED_NUM) : 1,
    parameter logic [31:0] START_WORD = 32'h0000_0000,
    parameter logic [31:0] END_WORD   = 32'hFFFF_FFFF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [28:0]   wr_data,
    input  logic          commit,
    output logic [31:0]   word_data,
    output logic          word_valid,
    input  logic          word_ready,
    output logic          word_last,
    output logic          swap_pending,
    output logic          frame_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_PIXEL = 2'd2,
        S_END   = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(LED_NUM - 1);

    state_t        state_reg, state_next;
    logic [AW-1:0] idx_reg, idx_next;
    logic [31:0]   word_data_reg, word_data_next;
    logic          word_valid_reg, word_valid_next;
    logic          word_last_reg, word_last_next;
    logic          frame_done_reg, frame_done_next;
    logic          bank_sel_reg, bank_sel_next;
    logic          pending_reg, pending_next;
    logic          swap;
    logic          accept;

    // Index of the LED word about to be presented, and its active-bank value.
    logic [AW-1:0] pix_idx;
    logic [28:0]   active_rd;
    logic [28:0]   bank0_rd [LED_NUM];
    logic [28:0]   bank1_rd [LED_NUM];

    assign accept  = word_valid_reg && word_ready;
    assign pix_idx = (state_reg == S_START) ? '0 : idx_reg + 1'b1;

    // Per-LED storage. Writes land in the shadow bank (the one not selected
    // by bank_sel). Out-of-range addresses never match any entry, so they
    // are dropped without side effects. Entries reset to zero, which is why
    // these are flops rather than a RAM.
    genvar gi;
    generate
        for (gi = 0; gi < LED_NUM; gi++) begin : g_led
            logic [28:0] b0_reg;
            logic [28:0] b1_reg;
            logic        hit;

            assign hit = wr_en && (wr_addr == AW'(gi));

            // Shadow-bank write for this LED entry.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b0_reg <= '0;
                    b1_reg <= '0;
                end else if (hit) begin
                    if (bank_sel_reg) begin
                        b0_reg <= wr_data;
                    end else begin
                        b1_reg <= wr_data;
                    end
                end
            end

            assign bank0_rd[gi] = b0_reg;
            assign bank1_rd[gi] = b1_reg;
        end
    endgenerate

    assign active_rd = bank_sel_reg ? bank1_rd[pix_idx] : bank0_rd[pix_idx];

    // Next-state, next-word and swap decision. Output words are computed
    // one step ahead so every output comes straight from a register.
    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        word_data_next  = word_data_reg;
        word_valid_next = word_valid_reg;
        word_last_next  = word_last_reg;
        frame_done_next = 1'b0;
        swap            = 1'b0;

        case (state_reg)
            S_IDLE: begin
                swap = pending_reg;
                if (run) begin
                    state_next      = S_START;
                    word_data_next  = START_WORD;
                    word_valid_next = 1'b1;
                    word_last_next  = 1'b0;
                end
            end
            S_START: begin
                if (accept) begin
                    state_next     = S_PIXEL;
                    idx_next       = '0;
                    word_data_next = {3'b111, active_rd};
                end
            end
            S_PIXEL: begin
                if (accept) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next     = S_END;
                        word_data_next = END_WORD;
                        word_last_next = 1'b1;
                    end else begin
                        idx_next       = pix_idx;
                        word_data_next = {3'b111, active_rd};
                    end
                end
            end
            S_END: begin
                if (accept) begin
                    frame_done_next = 1'b1;
                    swap            = pending_reg;
                    idx_next        = '0;
                    if (run) begin
                        state_next      = S_START;
                        word_data_next  = START_WORD;
                        word_last_next  = 1'b0;
                    end else begin
                        state_next      = S_IDLE;
                        word_data_next  = '0;
                        word_valid_next = 1'b0;
                        word_last_next  = 1'b0;
                    end
                end
            end
            default: begin
                state_next      = S_IDLE;
                word_data_next  = '0;
                word_valid_next = 1'b0;
                word_last_next  = 1'b0;
            end
        endcase

        // A swap consumes the pending request, including a commit arriving
        // in the same cycle.
        bank_sel_next = bank_sel_reg ^ swap;
        pending_next  = swap ? 1'b0 : (pending_reg | commit);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            idx_reg        <= '0;
            word_data_reg  <= '0;
            word_valid_reg <= 1'b0;
            word_last_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            bank_sel_reg   <= 1'b0;
            pending_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            word_data_reg  <= word_data_next;
            word_valid_reg <= word_valid_next;
            word_last_reg  <= word_last_next;
            frame_done_reg <= frame_done_next;
            bank_sel_reg   <= bank_sel_next;
            pending_reg    <= pending_next;
        end
    end

    assign word_data    = word_data_reg;
    assign word_valid   = word_valid_reg;
    assign word_last    = word_last_reg;
    assign frame_done   = frame_done_reg;
    assign swap_pending = pending_reg;

endmodule
